// File: rtl/load_store_unit_if.sv
// Bundle of signals between the EX stage, the load/store unit and the data memory.
// The "master" view belongs to the load/store unit: it receives the EX-stage
// request, drives the memory request and produces the write-back response.
// The "slave" view is the surrounding environment (EX stage plus data memory).
interface load_store_unit_if;
  // EX-stage request side
  logic        in_valid;
  logic        in_ready;
  logic        in_store;
  logic [2:0]  in_size;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;

  // Data-memory side
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // Write-back response
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    input  in_valid, in_store, in_size, in_addr, in_wdata,
    output in_ready,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata,
    output resp_valid, resp_data, resp_err
  );

  modport slave (
    output in_valid, in_store, in_size, in_addr, in_wdata,
    input  in_ready,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata,
    input  resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding memory access stage after the ALU.
// Aligns store data into byte lanes, extends load data, and returns the
// write-back value (or an error) as a one-cycle response pulse. Accesses that
// are misaligned or use an unsupported size never reach memory; accesses the
// memory fails to acknowledge within TIMEOUT_CYC cycles abort with an error.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter value seen in the last wait cycle before the access gives up
  localparam logic [15:0] LP_LAST_WAIT = 16'(TIMEOUT_CYC - 1);

  state_t      r_state, w_state_next;

  logic        r_store, w_store;
  logic [2:0]  r_size, w_size;
  logic [1:0]  r_off, w_off;
  logic [15:0] r_cnt, w_cnt;

  logic        r_mem_req, w_mem_req;
  logic        r_mem_we, w_mem_we;
  logic [31:0] r_mem_addr, w_mem_addr;
  logic [3:0]  r_mem_be, w_mem_be;
  logic [31:0] r_mem_wdata, w_mem_wdata;

  logic        r_resp_valid, w_resp_valid;
  logic [31:0] r_resp_data, w_resp_data;
  logic        r_resp_err, w_resp_err;

  logic        w_legal;
  logic        w_misaligned;
  logic [3:0]  w_be_in;
  logic [31:0] w_wdata_in;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;

  // Classify the incoming request and build its byte enables and lane-aligned store data
  always_comb begin
    w_legal      = 1'b0;
    w_misaligned = 1'b0;
    w_be_in      = 4'b1111;
    w_wdata_in   = bus.in_wdata;

    case (bus.in_size)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = !bus.in_store;
      default:                w_legal = 1'b0;
    endcase

    w_misaligned = ((bus.in_size[1:0] == 2'b01) && bus.in_addr[0]) ||
                   ((bus.in_size[1:0] == 2'b10) && (bus.in_addr[1:0] != 2'b00));

    case (bus.in_size[1:0])
      2'b00: begin
        w_be_in    = 4'b0001 << bus.in_addr[1:0];
        w_wdata_in = {4{bus.in_wdata[7:0]}} << {bus.in_addr[1:0], 3'b000};
      end
      2'b01: begin
        w_be_in    = 4'b0011 << bus.in_addr[1:0];
        w_wdata_in = {2{bus.in_wdata[15:0]}} << {bus.in_addr[1:0], 3'b000};
      end
      default: begin
        w_be_in    = 4'b1111;
        w_wdata_in = bus.in_wdata;
      end
    endcase
  end

  // Pick the addressed byte/halfword out of the read word and sign- or zero-extend it
  always_comb begin
    w_byte     = 8'h00;
    w_half     = 16'h0000;
    w_load_ext = bus.mem_rdata;

    case (r_off)
      2'd0:    w_byte = bus.mem_rdata[7:0];
      2'd1:    w_byte = bus.mem_rdata[15:8];
      2'd2:    w_byte = bus.mem_rdata[23:16];
      default: w_byte = bus.mem_rdata[31:24];
    endcase

    w_half = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    case (r_size)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_ext = {24'h000000, w_byte};
      3'b101:  w_load_ext = {16'h0000, w_half};
      default: w_load_ext = bus.mem_rdata;
    endcase
  end

  // Next-state and next-output logic; every register holds unless a transition updates it
  always_comb begin
    w_state_next = r_state;
    w_store      = r_store;
    w_size       = r_size;
    w_off        = r_off;
    w_cnt        = r_cnt;
    w_mem_req    = r_mem_req;
    w_mem_we     = r_mem_we;
    w_mem_addr   = r_mem_addr;
    w_mem_be     = r_mem_be;
    w_mem_wdata  = r_mem_wdata;
    w_resp_valid = 1'b0;
    w_resp_data  = r_resp_data;
    w_resp_err   = r_resp_err;

    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_store = bus.in_store;
          w_size  = bus.in_size;
          w_off   = bus.in_addr[1:0];
          if (!w_legal || w_misaligned) begin
            w_resp_valid = 1'b1;
            w_resp_err   = 1'b1;
            w_resp_data  = 32'h0000_0000;
            w_state_next = RESP;
          end else begin
            w_mem_req    = 1'b1;
            w_mem_we     = bus.in_store;
            w_mem_addr   = {bus.in_addr[31:2], 2'b00};
            w_mem_be     = w_be_in;
            w_mem_wdata  = w_wdata_in;
            w_cnt        = 16'h0000;
            w_state_next = REQ;
          end
        end
      end

      REQ: begin
        if (bus.mem_ack) begin
          w_mem_req    = 1'b0;
          w_mem_we     = 1'b0;
          w_resp_valid = 1'b1;
          w_resp_err   = 1'b0;
          w_resp_data  = r_store ? 32'h0000_0000 : w_load_ext;
          w_state_next = RESP;
        end else if (r_cnt == LP_LAST_WAIT) begin
          w_mem_req    = 1'b0;
          w_mem_we     = 1'b0;
          w_resp_valid = 1'b1;
          w_resp_err   = 1'b1;
          w_resp_data  = 32'h0000_0000;
          w_state_next = RESP;
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end

      RESP: begin
        w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any access in flight without a response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_store      <= 1'b0;
      r_size       <= 3'b000;
      r_off        <= 2'b00;
      r_cnt        <= 16'h0000;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'h0000_0000;
      r_mem_be     <= 4'b0000;
      r_mem_wdata  <= 32'h0000_0000;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'h0000_0000;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_store      <= w_store;
      r_size       <= w_size;
      r_off        <= w_off;
      r_cnt        <= w_cnt;
      r_mem_req    <= w_mem_req;
      r_mem_we     <= w_mem_we;
      r_mem_addr   <= w_mem_addr;
      r_mem_be     <= w_mem_be;
      r_mem_wdata  <= w_mem_wdata;
      r_resp_valid <= w_resp_valid;
      r_resp_data  <= w_resp_data;
      r_resp_err   <= w_resp_err;
    end
  end

  assign bus.in_ready   = (r_state == IDLE);
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_be     = r_mem_be;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_err   = r_resp_err;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU.
- Takes the ALU result as the effective address, plus the store operand and access type.
- Runs a single-outstanding request/acknowledge transaction to the data memory, aligns store data with byte enables, and sign/zero-extends load data.
- Returns the write-back value, or an error, through a one-cycle response pulse.

Parameters:
- TIMEOUT_CYC, 255, maximum number of cycles mem_req may wait for mem_ack before the access aborts with an error; range 1..65535.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  access request from the EX stage.
- in_ready  output  1  unit can accept a request (IDLE only).
- in_store  input  1  1 = store, 0 = load.
- in_size  input  3  funct3 code:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - stores: 000 SB, 001 SH, 010 SW.
- in_addr  input  32  effective address (ALU out).
- in_wdata  input  32  store operand (rs2).
- mem_req  output  1  memory request, held until ack.
- mem_we  output  1  write enable, qualified by mem_req.
- mem_addr  output  32  word address, {in_addr[31:2],2'b00}.
- mem_be  output  4  byte enables.
- mem_wdata  output  32  lane-shifted store data.
- mem_ack  input  1  memory completes the access this cycle.
- mem_rdata  input  32  read word, valid when mem_ack=1.
- resp_valid  output  1  one-cycle completion pulse.
- resp_data  output  32  extended load result; 0 for stores and errors.
- resp_err  output  1  valid with resp_valid: misaligned, illegal size or timeout.

Behaviour:
- States: IDLE, REQ, RESP.
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1.
  - mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
  - resp_valid=0, resp_data=0, resp_err=0, timeout counter=0.
  - Reset mid-transaction drops the request immediately; no response is produced.
- in_ready = (state==IDLE), combinational from state.

IDLE, on in_valid=1:
- Latch the request.
- Illegal size, or misaligned access (halfword with addr[0]=1, word with addr[1:0]≠0): go to RESP with resp_err=1; no mem_req is issued.
- Otherwise go to REQ:
  - Register mem_req=1 and mem_we=in_store.
  - mem_be: byte = 0001<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111.
  - mem_wdata = in_wdata replicated per size and shifted into the byte lane(s).
- With in_valid=0, outputs hold.

REQ:
- mem_req and all mem_* outputs are stable until ack.
- Counter increments each cycle with mem_ack=0.
- On mem_ack=1:
  - Capture and extend the load data: select the byte/half by addr[1:0], sign-extend for LB/LH, zero-extend for LBU/LHU.
  - Stores give resp_data=0.
  - Deassert mem_req next cycle; go to RESP.
- If the counter reaches TIMEOUT_CYC with no ack: deassert mem_req, go to RESP with resp_err=1, resp_data=0.
- mem_ack outside REQ is ignored.

RESP:
- resp_valid=1 for exactly one cycle; next state is IDLE.
- resp_data and resp_err hold their values until the next response; resp_valid returns to 0.

Latency:
- Accept at edge 0; mem_req high in cycle 1.
- Ack in cycle k gives resp_valid in cycle k+1; in_ready is back at 1 in cycle k+2.
- Zero-wait memory: 2 cycles from accept to response.
- Error path: resp_valid in cycle 1.

Test Plan:
- LW addr=0x100, ack in cycle 1 with rdata=0xDEADBEEF -> mem_addr=0x100, be=1111, we=0; resp_valid in cycle 2, resp_data=0xDEADBEEF, err=0.
- LB addr=0x103, rdata=0x80FF_0000 -> be=1000; resp_data=0xFFFFFF80. Repeat as LBU -> 0x00000080.
- SH addr=0x202, wdata=0x1234ABCD -> mem_we=1, mem_addr=0x200, be=1100, mem_wdata[31:16]=0xABCD; resp_data=0, err=0.
- LW addr=0x101 -> mem_req never asserted; resp_valid with resp_err=1 in cycle 1. Size 011 behaves the same.
- Ack withheld with TIMEOUT_CYC=4 -> mem_req drops after 4 wait cycles, resp_err=1. Ack delayed 3 cycles -> mem_* outputs stable throughout, normal response.
- rst_n pulsed low while in REQ -> mem_req=0 asynchronously, no resp_valid, in_ready=1 after release.
